// File: rtl/result_check_pkg.sv
// Shared types and helpers for the result stream checker.
//   state_t   : checker FSM states
//   *_DEF     : default word / index widths
//   sat_inc   : increment that sticks at the all-ones value of a w-bit field
package result_check_pkg;

    localparam int unsigned RES_W_DEF = 10;
    localparam int unsigned IDX_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturating increment of a w-bit value carried in a 32-bit container (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous skid FIFO with registered storage and a synchronous flush.
//   push/wdata : write when push (caller guarantees !full)
//   pop/rdata  : rdata is the current head; pop advances it (caller guarantees !empty)
//   flush      : empties the FIFO, overriding push and pop in the same cycle
//   full/empty : occupancy flags decoded from the pointers
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/result_stream_checker.sv
// Compares a stream of result words against a golden stream, pair by pair.
//   start/expected_count       : begin (or restart) a run of expected_count pairs
//   res_* / gold_*             : valid/ready input streams, each buffered in a skid FIFO
//   busy/done/pass             : run status; pass = done with zero mismatches
//   mismatch_count             : saturating count of mismatching pairs
//   first_fail_idx/got/exp     : index and words of the first mismatching pair
//   fail_seen                  : at least one mismatch recorded this run
module result_stream_checker
    import result_check_pkg::*;
#(
    parameter int unsigned RES_W = RES_W_DEF,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] expected_count,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [RES_W-1:0] res_data,
    input  logic             gold_valid,
    output logic             gold_ready,
    input  logic [RES_W-1:0] gold_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] mismatch_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [RES_W-1:0] first_fail_got,
    output logic [RES_W-1:0] first_fail_exp,
    output logic             fail_seen
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] exp_cnt, exp_cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W-1:0] mis_nxt, ff_idx_nxt;
    logic [RES_W-1:0] ff_got_nxt, ff_exp_nxt;
    logic             fail_seen_nxt, busy_nxt, done_nxt, pass_nxt;

    logic             res_full, res_empty, gold_full, gold_empty;
    logic [RES_W-1:0] res_head, gold_head;
    logic             cmp_c;

    // Ready depends only on state and occupancy, never on valid.
    assign res_ready  = (state == RUN) && !res_full;
    assign gold_ready = (state == RUN) && !gold_full;

    // A start in the same cycle wins over a compare.
    assign cmp_c = (state == RUN) && !start && !res_empty && !gold_empty && (idx < exp_cnt);

    sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_valid && res_ready),
        .wdata (res_data),
        .pop   (cmp_c),
        .flush (start),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty)
    );

    sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_gold_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gold_valid && gold_ready),
        .wdata (gold_data),
        .pop   (cmp_c),
        .flush (start),
        .rdata (gold_head),
        .full  (gold_full),
        .empty (gold_empty)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        exp_cnt_nxt   = exp_cnt;
        idx_nxt       = idx;
        mis_nxt       = mismatch_count;
        ff_idx_nxt    = first_fail_idx;
        ff_got_nxt    = first_fail_got;
        ff_exp_nxt    = first_fail_exp;
        fail_seen_nxt = fail_seen;

        if (start) begin
            // A zero-length run completes immediately.
            exp_cnt_nxt   = expected_count;
            idx_nxt       = '0;
            mis_nxt       = '0;
            ff_idx_nxt    = '0;
            ff_got_nxt    = '0;
            ff_exp_nxt    = '0;
            fail_seen_nxt = 1'b0;
            state_nxt     = (expected_count == '0) ? DONE : RUN;
        end else if (cmp_c) begin
            idx_nxt = idx + IDX_W'(1);
            if (res_head != gold_head) begin
                mis_nxt = IDX_W'(sat_inc(32'(mismatch_count), IDX_W));
                if (!fail_seen) begin
                    ff_idx_nxt    = idx;
                    ff_got_nxt    = res_head;
                    ff_exp_nxt    = gold_head;
                    fail_seen_nxt = 1'b1;
                end
            end
            if (idx == exp_cnt - IDX_W'(1)) state_nxt = DONE;
        end

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        pass_nxt = (state_nxt == DONE) && (mis_nxt == '0);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            exp_cnt        <= '0;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            first_fail_exp <= '0;
            fail_seen      <= 1'b0;
        end else begin
            state          <= state_nxt;
            exp_cnt        <= exp_cnt_nxt;
            idx            <= idx_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            mismatch_count <= mis_nxt;
            first_fail_idx <= ff_idx_nxt;
            first_fail_got <= ff_got_nxt;
            first_fail_exp <= ff_exp_nxt;
            fail_seen      <= fail_seen_nxt;
        end
    end

endmodule

// File: tb/tb_result_stream_checker.sv
// Self-checking bench for result_stream_checker: directed table, multi-cycle
// corner sequences and randomized runs against a pair-list reference model.
module tb_result_stream_checker;

    localparam int unsigned RES_W = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDX_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [IDX_W-1:0] expected_count;
    logic             res_valid, res_ready, gold_valid, gold_ready;
    logic [RES_W-1:0] res_data, gold_data;
    logic             busy, done, pass, fail_seen;
    logic [IDX_W-1:0] mismatch_count, first_fail_idx;
    logic [RES_W-1:0] first_fail_got, first_fail_exp;

    result_stream_checker #(.RES_W(RES_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .expected_count (expected_count),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .gold_valid     (gold_valid),
        .gold_ready     (gold_ready),
        .gold_data      (gold_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_got (first_fail_got),
        .first_fail_exp (first_fail_exp),
        .fail_seen      (fail_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stream sources: words waiting to be offered, offer rate in percent, accept counters.
    logic [RES_W-1:0] res_q[$];
    logic [RES_W-1:0] gold_q[$];
    int res_rate  = 100;
    int gold_rate = 100;
    int res_acc   = 0;
    int gold_acc  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drivers change inputs on the falling edge; ready is stable then, so an offer
    // made while ready is high is taken at the next rising edge.
    initial begin
        res_valid  = 1'b0;
        gold_valid = 1'b0;
        res_data   = '0;
        gold_data  = '0;
        forever begin
            @(negedge clk);
            if (res_q.size() > 0 && $urandom_range(0, 99) < res_rate) begin
                res_valid = 1'b1;
                res_data  = res_q[0];
                if (res_ready && rst_n) begin
                    void'(res_q.pop_front());
                    res_acc++;
                end
            end else begin
                res_valid = 1'b0;
            end
            if (gold_q.size() > 0 && $urandom_range(0, 99) < gold_rate) begin
                gold_valid = 1'b1;
                gold_data  = gold_q[0];
                if (gold_ready && rst_n) begin
                    void'(gold_q.pop_front());
                    gold_acc++;
                end
            end else begin
                gold_valid = 1'b0;
            end
        end
    end

    task automatic start_run(input int n);
        @(negedge clk);
        res_q.delete();
        gold_q.delete();
        expected_count = IDX_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic chk_verdict(input string name, input int mism, input int fidx,
                               input logic [RES_W-1:0] fgot, input logic [RES_W-1:0] fexp,
                               input logic fseen, input logic pss);
        chk({name, "_pass"},      32'(pass),           32'(pss));
        chk({name, "_mismatch"},  32'(mismatch_count), 32'(mism));
        chk({name, "_fail_seen"}, 32'(fail_seen),      32'(fseen));
        chk({name, "_ff_idx"},    32'(first_fail_idx), 32'(fidx));
        chk({name, "_ff_got"},    32'(first_fail_got), 32'(fgot));
        chk({name, "_ff_exp"},    32'(first_fail_exp), 32'(fexp));
    endtask

    typedef struct {
        int               n;
        logic [RES_W-1:0] r[6];
        logic [RES_W-1:0] g[6];
        int               mism;
        int               fidx;
        logic [RES_W-1:0] fgot;
        logic [RES_W-1:0] fexp;
        logic             fseen;
        logic             pss;
    } vec_t;

    vec_t vt[4];

    initial begin
        int acc_r, acc_g;
        rst_n          = 1'b0;
        start          = 1'b0;
        expected_count = '0;

        vt[0] = '{n: 3, r: '{10'h3FF, 10'h001, 10'h155, 0, 0, 0},
                        g: '{10'h3FF, 10'h001, 10'h155, 0, 0, 0},
                  mism: 0, fidx: 0, fgot: 10'h000, fexp: 10'h000, fseen: 1'b0, pss: 1'b1};
        vt[1] = '{n: 4, r: '{10'h100, 10'h200, 10'h010, 10'h000, 0, 0},
                        g: '{10'h100, 10'h200, 10'h011, 10'h3FF, 0, 0},
                  mism: 2, fidx: 2, fgot: 10'h010, fexp: 10'h011, fseen: 1'b1, pss: 1'b0};
        vt[2] = '{n: 1, r: '{10'h2AA, 0, 0, 0, 0, 0},
                        g: '{10'h155, 0, 0, 0, 0, 0},
                  mism: 1, fidx: 0, fgot: 10'h2AA, fexp: 10'h155, fseen: 1'b1, pss: 1'b0};
        vt[3] = '{n: 6, r: '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006},
                        g: '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h3FF},
                  mism: 1, fidx: 5, fgot: 10'h006, fexp: 10'h3FF, fseen: 1'b1, pss: 1'b0};

        // Reset state
        #12;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_pass",  32'(pass), 0);
        chk("rst_ready", 32'({res_ready, gold_ready}), 0);
        chk("rst_fields", 32'(mismatch_count | first_fail_idx | IDX_W'(first_fail_got)
                              | IDX_W'(first_fail_exp) | IDX_W'(fail_seen)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table
        res_rate  = 100;
        gold_rate = 100;
        for (int t = 0; t < 4; t++) begin
            start_run(vt[t].n);
            chk($sformatf("vec%0d_busy", t), 32'(busy), 1);
            for (int i = 0; i < vt[t].n; i++) begin
                res_q.push_back(vt[t].r[i]);
                gold_q.push_back(vt[t].g[i]);
            end
            wait_done($sformatf("vec%0d", t), 100);
            chk_verdict($sformatf("vec%0d", t), vt[t].mism, vt[t].fidx, vt[t].fgot,
                        vt[t].fexp, vt[t].fseen, vt[t].pss);
        end

        // Skew: golden idle while six results are offered
        start_run(6);
        acc_r = res_acc;
        for (int i = 0; i < 6; i++) res_q.push_back(RES_W'(10'h0A0 + i));
        repeat (12) @(negedge clk);
        chk("skew_accepted", 32'(res_acc - acc_r), 32'd4);
        chk("skew_res_ready", 32'(res_ready), 0);
        chk("skew_no_compare", 32'(mismatch_count), 0);
        for (int i = 0; i < 6; i++) gold_q.push_back(RES_W'(10'h0A0 + i));
        wait_done("skew", 100);
        chk_verdict("skew", 0, 0, 10'h000, 10'h000, 1'b0, 1'b1);

        // Zero-length run
        start_run(0);
        chk("zero_done", 32'(done), 1);
        chk("zero_pass", 32'(pass), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_ready", 32'({res_ready, gold_ready}), 0);
        res_q.push_back(10'h111);
        gold_q.push_back(10'h111);
        repeat (3) @(negedge clk);
        chk("zero_ready_later", 32'({res_ready, gold_ready}), 0);

        // Restart mid-run after 2 of 5 compares with one mismatch
        start_run(5);
        for (int i = 0; i < 5; i++) res_q.push_back(RES_W'(10'h300 + i));
        gold_q.push_back(10'h300);
        gold_q.push_back(10'h0FF);
        repeat (10) @(negedge clk);
        chk("restart_pre_mismatch", 32'(mismatch_count), 1);
        chk("restart_pre_busy", 32'(busy), 1);
        start_run(5);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_cleared", 32'(mismatch_count | first_fail_idx | IDX_W'(first_fail_got)
                                   | IDX_W'(first_fail_exp) | IDX_W'(fail_seen)), 0);
        for (int i = 0; i < 5; i++) begin
            res_q.push_back(RES_W'(10'h040 + i));
            gold_q.push_back(RES_W'(10'h040 + i));
        end
        wait_done("restart", 100);
        chk_verdict("restart", 0, 0, 10'h000, 10'h000, 1'b0, 1'b1);

        // Asynchronous reset mid-run
        start_run(5);
        for (int i = 0; i < 5; i++) res_q.push_back(RES_W'(10'h200 + i));
        gold_q.push_back(10'h200);
        gold_q.push_back(10'h3AA);
        repeat (10) @(negedge clk);
        chk("arst_pre_mismatch", 32'(mismatch_count), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_status", 32'({busy, done, pass, fail_seen}), 0);
        chk("arst_ready", 32'({res_ready, gold_ready}), 0);
        chk("arst_fields", 32'(mismatch_count | first_fail_idx | IDX_W'(first_fail_got)
                               | IDX_W'(first_fail_exp)), 0);
        res_q.delete();
        gold_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc_r = res_acc;
        acc_g = gold_acc;
        for (int i = 0; i < 3; i++) begin
            res_q.push_back(10'h123);
            gold_q.push_back(10'h123);
        end
        repeat (6) @(negedge clk);
        chk("arst_idle_no_accept", 32'((res_acc - acc_r) + (gold_acc - acc_g)), 0);
        chk("arst_idle_ready", 32'({res_ready, gold_ready, busy}), 0);
        start_run(2);
        res_q.push_back(10'h00A);
        res_q.push_back(10'h00B);
        gold_q.push_back(10'h00A);
        gold_q.push_back(10'h00B);
        wait_done("arst_recover", 100);
        chk_verdict("arst_recover", 0, 0, 10'h000, 10'h000, 1'b0, 1'b1);

        // Randomized runs against a pair-list model
        for (int run = 0; run < 25; run++) begin
            logic [RES_W-1:0] r[$];
            logic [RES_W-1:0] g[$];
            int n, mism, fidx;
            logic [RES_W-1:0] fgot, fexp;
            logic fseen;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic [RES_W-1:0] w;
                w = RES_W'($urandom);
                r.push_back(w);
                if ($urandom_range(0, 99) < 25) g.push_back(w ^ RES_W'($urandom_range(1, 1023)));
                else g.push_back(w);
            end
            mism = 0; fidx = 0; fgot = '0; fexp = '0; fseen = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (r[i] != g[i]) begin
                    if (!fseen) begin
                        fidx = i; fgot = r[i]; fexp = g[i]; fseen = 1'b1;
                    end
                    mism++;
                end
            end
            res_rate  = $urandom_range(30, 100);
            gold_rate = $urandom_range(30, 100);
            start_run(n);
            for (int i = 0; i < n; i++) begin
                res_q.push_back(r[i]);
                gold_q.push_back(g[i]);
            end
            wait_done($sformatf("rnd%0d", run), 400);
            chk_verdict($sformatf("rnd%0d", run), mism, fidx, fgot, fexp, fseen, (mism == 0));
            // Surplus words after completion must not be taken
            acc_r = res_acc;
            acc_g = gold_acc;
            res_q.push_back(10'h3C3);
            gold_q.push_back(10'h3C3);
            repeat (6) @(negedge clk);
            chk($sformatf("rnd%0d_surplus", run), 32'((res_acc - acc_r) + (gold_acc - acc_g)), 0);
            chk($sformatf("rnd%0d_hold", run), 32'({done, pass}), 32'({1'b1, mism == 0}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
